// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int CNT_W = 3;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_M0   = 2'b01;
  localparam logic [1:0] G_M1   = 2'b10;

endpackage

// File: rtl/mem_arb_if.sv
// Requester handshakes, memory pins and status of the arbiter, bundled as one port.
interface mem_arb_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_ack;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_ack;

  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    grant;
  logic          busy;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_ack, m1_ack, rdata,
    output mem_addr, mem_wdata, mem_we, grant, busy
  );

  // Requesters and memory side.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_ack, m1_ack, rdata,
    input  mem_addr, mem_wdata, mem_we, grant, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way combinational pick: a lone requester wins, ties go by priority mode.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    // NOTE: default first so every path assigns win and no latch is inferred.
    win = G_NONE;
    case (req)
      G_M0:    win = G_M0;
      G_M1:    win = G_M1;
      2'b11:   win = ((FIXED_PRI != 0) || last) ? G_M0 : G_M1;
      default: win = G_NONE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port between two req/ack masters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MEM_LAT   = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic      clk,
  input  logic      reset,
  mem_arb_if.slave  bus
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic               lat_we;
  logic               m0_ack;
  logic               m1_ack;
  logic               mem_we;
  logic               busy;
  logic [1:0]         grant;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      rdata;

  logic [1:0]         win;
  logic               sel_we;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;

  rr_arb2 #(.FIXED_PRI(FIXED_PRI)) u_arb (
    .req  ({bus.m1_req, bus.m0_req}),
    .last (last),
    .win  (win)
  );

  assign sel_we    = win[1] ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = win[1] ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = win[1] ? bus.m1_wdata : bus.m0_wdata;

  // Memory pins are loaded on entry to ACCESS so they are registered outputs
  // that already show the transaction during the ACCESS cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: non-blocking everywhere here; all state updates see pre-edge values.
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      lat_we    <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      grant     <= G_NONE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win != G_NONE) begin
            state     <= ACCESS;
            grant     <= win;
            busy      <= 1'b1;
            lat_we    <= sel_we;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            last      <= (win == G_M1);
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (lat_we) begin
            state  <= DONE;
            m0_ack <= (grant == G_M0);
            m1_ack <= (grant == G_M1);
          end else begin
            state <= WAIT;
            cnt   <= CNT_W'(MEM_LAT);
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            rdata  <= bus.mem_rdata;
            state  <= DONE;
            m0_ack <= (grant == G_M0);
            m1_ack <= (grant == G_M1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          grant  <= G_NONE;
          busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m0_ack    = m0_ack;
  assign bus.m1_ack    = m1_ack;
  assign bus.rdata     = rdata;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_we    = mem_we;
  assign bus.grant     = grant;
  assign bus.busy      = busy;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 16-bit data memory between two requesters: master 0 (the RISC core load/store/fetch port) and master 1 (the DMA/program loader).
- Sits between the requesters and the memory pins `Address`, `D_Out`, `D_in` and `mw_en`.
- Provides a req/ack handshake per master, round-robin or fixed-priority arbitration, and configurable synchronous-read latency.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- MEM_LAT, 1, memory read latency in cycles. Legal range 1..4.
- FIXED_PRI, 0, arbitration mode. 0 = round-robin; 1 = master 0 always wins.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- m0_req  input  1  master 0 request. Held high until m0_ack.
- m0_we  input  1  master 0 write (1) / read (0). Stable while req is high.
- m0_addr  input  AW  master 0 address. Stable while req is high.
- m0_wdata  input  DW  master 0 write data. Stable while req is high.
- m0_ack  output  1  one-cycle completion pulse to master 0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack  same as the m0_* ports, for master 1.
- rdata  output  DW  registered read data. Valid in the ack cycle; held until the next read completes.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_we  output  1  memory write enable.
- mem_rdata  input  DW  memory read data. Valid MEM_LAT cycles after the address is presented.
- grant  output  2  one-hot current owner; 00 when idle.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE; m0_ack, m1_ack, mem_we, grant, busy = 0; mem_addr, mem_wdata, rdata = 0; round-robin pointer `last` = 1, so master 0 wins the first tie.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any req is high, select the winner, latch its we/addr/wdata, set grant, go to ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration:
  - FIXED_PRI=0: on a tie, the master not equal to `last` wins. `last` updates at grant.
  - FIXED_PRI=1: master 0 wins every tie; `last` is unused.
  - A lone requester always wins.
- ACCESS (one cycle):
  - mem_addr and mem_wdata are driven from the latched values.
  - mem_we = 1 for writes only.
  - Write: go to DONE.
  - Read: go to WAIT with count = MEM_LAT.
- WAIT:
  - mem_we = 0; mem_addr is held.
  - Decrement count each cycle.
  - When count reaches 1, capture mem_rdata into rdata at that edge and go to DONE.
- DONE (one cycle):
  - The ack of the granted master is 1.
  - Next cycle: grant = 00, state IDLE.
- Latency, with the request seen in IDLE in cycle 0:
  - Write: mem_we is high in cycle 1; ack in cycle 2.
  - Read: address in cycle 1, data captured at the end of cycle 1+MEM_LAT, ack in cycle 2+MEM_LAT.
- Masters must drop req, or present a new request, by the edge after their ack. Because DONE always returns to IDLE, the served master's stale req is never re-granted in the DONE cycle.
- Back-to-back throughput is one access per 3 cycles (write) or 3+MEM_LAT cycles (read).
- A req that drops mid-transaction (protocol violation) does not abort the access: it completes and ack still pulses.
- A req arriving while busy waits. It is arbitrated in the next IDLE cycle.
- mem_we is never high outside ACCESS.
- mem_addr and mem_wdata hold their last values while IDLE.
- Reset low in any state: at the next edge, state goes to IDLE; mem_we, ack and grant go to 0; no ack is issued for the aborted transaction; rdata is cleared.
- Simultaneous events:
  - Both reqs rise together: exactly one grant is issued. The loser is served next, with no starvation in round-robin mode.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding constants: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3;
  - the wait-counter width (3 bits);
  - grant encodings G_NONE=2'b00, G_M0=2'b01, G_M1=2'b10.
- Sub-module rr_arb2: combinational two-way pick from req[1:0], `last` and FIXED_PRI, producing a one-hot winner. The `last` register stays in mem_arbiter.

Test Plan:
- Reset hold then release, no reqs: all outputs 0, grant 00, busy 0 for 10 cycles.
- m0 write, addr 0x0010, data 0xBEEF: mem_we=1 with mem_addr=0x0010 and mem_wdata=0xBEEF in cycle 1; m0_ack in cycle 2; m1_ack stays 0.
- m1 read, addr 0x0010, MEM_LAT=1, memory model returns 0xBEEF: m1_ack in cycle 3 with rdata=0xBEEF. With MEM_LAT=3: ack in cycle 5.
- Both reqs high every cycle, FIXED_PRI=0: grants alternate m0, m1, m0, m1. With FIXED_PRI=1: only m0 is served while its req stays high.
- Reset driven low in the WAIT state of a read: next cycle state IDLE, no ack, rdata=0. A new m0 read afterwards completes normally.
- m0_req dropped in ACCESS: m0_ack still pulses in DONE, and mem_we never rises again.
